naive_divider: RTL and testbench

NAIVE_DIVIDER -- requirements
Module: naive_divider

---
 rtl/naive_divider_pkg.sv | 16 +
 rtl/naive_divider_step.sv | 29 ++
 rtl/naive_divider.sv | 155 +++++++++++++++
 tb/tb_naive_divider.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/naive_divider_pkg.sv
// Shared definitions for the naive radix-2 restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package naive_divider_pkg;

    // Operand width used when the instantiating code does not override LEN.
    localparam int DEFAULT_LEN = 32;

    // Controller states: accepting operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/naive_divider_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module naive_divider_step
    import naive_divider_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic [LEN-1:0] rem,
    input  logic [LEN-1:0] quo,
    input  logic [LEN-1:0] div,
    output logic [LEN-1:0] rem_next,
    output logic [LEN-1:0] quo_next
);

    // The shifted partial remainder needs one extra bit: 2*rem+1 can exceed LEN bits.
    logic [LEN:0]   trial;
    logic           fits;
    logic [LEN-1:0] diff;

    assign trial = {rem, quo[LEN-1]};

    // No borrow when the divisor fits; the difference is then below div, so LEN bits suffice.
    assign fits     = (trial >= {1'b0, div});
    assign diff     = trial[LEN-1:0] - div;
    assign rem_next = fits ? diff : trial[LEN-1:0];
    assign quo_next = {quo[LEN-2:0], fits};

endmodule

// File: rtl/naive_divider.sv
// Iterative divider, one quotient bit per cycle; signed mode under NAIVE_DIVIDER_SIGNED_EN.
// Latency: out_valid LEN+1 cycles after the accept cycle, 1 cycle for a zero divisor.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no turnaround).
module naive_divider
    import naive_divider_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] quotient,
    output logic [LEN-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = $clog2(LEN + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [LEN-1:0]   rem_q;
    logic [LEN-1:0]   quo_q;
    logic [LEN-1:0]   div_q;
    logic [LEN-1:0]   rem_step;
    logic [LEN-1:0]   quo_step;
    logic [LEN-1:0]   a_mag;
    logic [LEN-1:0]   b_mag;
    logic [LEN-1:0]   quo_fin;
    logic [LEN-1:0]   rem_fin;
    logic             b_zero;
    logic             last_step;

    assign b_zero    = (b == '0);
    assign last_step = (cnt == CNT_W'(LEN - 1));

`ifdef NAIVE_DIVIDER_SIGNED_EN
    // Result signs are decided at accept time; the core always divides magnitudes.
    logic neg_quo;
    logic neg_rem;

    assign a_mag   = a[LEN-1] ? (~a + 1'b1) : a;
    assign b_mag   = b[LEN-1] ? (~b + 1'b1) : b;
    assign quo_fin = neg_quo ? (~quo_step + 1'b1) : quo_step;
    assign rem_fin = neg_rem ? (~rem_step + 1'b1) : rem_step;

    // Capture operand signs; the most-negative / -1 case falls out naturally as quotient = a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_quo <= a[LEN-1] ^ b[LEN-1];
            neg_rem <= a[LEN-1];
        end
    end
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign quo_fin = quo_step;
    assign rem_fin = rem_step;
`endif

    naive_divider_step #(
        .LEN(LEN)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .div      (div_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; handshake outputs depend on state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = b_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in BUSY, publish to the result registers on the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        rem_q <= '0;
                        quo_q <= a_mag;
                        div_q <= b_mag;
                        if (b_zero) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        quotient    <= quo_fin;
                        remainder   <= rem_fin;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_naive_divider.sv
// Scoreboard bench for naive_divider: directed vectors, backpressure, reset, random pairs.
// Latency: checks LEN+1 (or 1 for zero divisor) cycles from accept to first out_valid.
// Backpressure: out_ready forced low or randomised; results must hold until taken.
module tb_naive_divider;

    localparam int LEN = 32;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [LEN-1:0] a         = '0;
    logic [LEN-1:0] b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;
    logic           div_by_zero;

    typedef struct {
        logic [LEN-1:0] q;
        logic [LEN-1:0] r;
        logic           dbz;
        int             lat;
        int             acc;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    bit   rand_rdy  = 1'b0;
    bit   force_rdy = 1'b1;
    bit   prev_vld  = 1'b0;

    naive_divider #(.LEN(LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready, changed shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // Monitor: compare every cycle a result is presented, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_result: got q=%h r=%h dbz=%b with nothing expected",
                             quotient, remainder, div_by_zero);
                end else begin
                    head = sb[0];
                    if (!prev_vld) begin
                        n_vec++;
                        if (cyc - head.acc != head.lat) begin
                            n_bad++;
                            $display("FAIL latency: got %0d cycles expected %0d", cyc - head.acc, head.lat);
                        end
                    end
                    n_vec++;
                    if (quotient !== head.q || remainder !== head.r || div_by_zero !== head.dbz) begin
                        n_bad++;
                        $display("FAIL result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                                 quotient, remainder, div_by_zero, head.q, head.r, head.dbz);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_vld = out_valid && !out_ready;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference model for random pairs.
    function automatic exp_t model(input logic [LEN-1:0] av, input logic [LEN-1:0] bv);
        exp_t e;
        e.acc = 0;
        e.lat = 0;
        e.dbz = 1'b0;
        e.q   = '0;
        e.r   = '0;
        if (bv == '0) begin
            e.q   = '1;
            e.r   = av;
            e.dbz = 1'b1;
        end
`ifdef NAIVE_DIVIDER_SIGNED_EN
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            e.q = av;
            e.r = '0;
        end else begin
            e.q = $signed(av) / $signed(bv);
            e.r = $signed(av) % $signed(bv);
        end
`else
        else begin
            e.q = av / bv;
            e.r = av % bv;
        end
`endif
        return e;
    endfunction

    // Present an operand pair, hold it until accepted, push the expected result.
    task automatic do_op(input logic [LEN-1:0] av, input logic [LEN-1:0] bv,
                         input logic [LEN-1:0] eq, input logic [LEN-1:0] er, input logic edbz);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
            in_valid = 1'b0;
            return;
        end
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.lat = (bv == '0) ? 1 : LEN + 1;
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        exp_t e;
        logic [LEN-1:0] av, bv;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic unsigned example and ready-again check.
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        drain();
        @(negedge clk);
        chk("ready_after_result", 64'(in_ready), 64'd1);

        // Directed vectors.
        do_op(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
`ifdef NAIVE_DIVIDER_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
        do_op(32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
        do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0);
        do_op(32'hFFFF_FFF7, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
`else
        do_op(32'd7,         32'd100,        32'd0,         32'd7,         1'b0);
        do_op(32'd0,         32'd5,          32'd0,         32'd0,         1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         32'd0,         1'b0);
        do_op(32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF, 32'd1,         1'b0);
        do_op(32'h8000_0000, 32'd3,          32'h2AAA_AAAA, 32'd2,         1'b0);
        do_op(32'd1000000,   32'd1000,       32'd1000,      32'd0,         1'b0);
`endif
        drain();

        // Backpressure: hold the result while a new pair waits on in_valid.
        force_rdy = 1'b0;
        do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        fork
            do_op(32'h0000_00C8, 32'd10, 32'd20, 32'd0, 1'b0);
        join_none
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        force_rdy = 1'b1;
        wait fork;
        drain();

        // Reset in the middle of BUSY discards the operation.
        do_op(32'h0012_3456, 32'd23, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_no_result", 64'(out_valid), 64'd0);
        do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        drain();

        // Random pairs with random gaps and downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            av = $urandom;
            bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 15) == 0) av = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) bv = 32'hFFFF_FFFF;
            e = model(av, bv);
            do_op(av, bv, e.q, e.r, e.dbz);
        end
        drain();
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
